adder_arbiter: RTL and testbench
================================

# adder_arbiter

Shares one `pipelined_adder` (fixed latency, no stall) between `NREQ` requesters. Per cycle it accepts at most one request using a valid/ready handshake and round-robin grant. It registers the operands into the adder and carries each requester ID through a tag pipeline matched to the adder depth. When the result emerges, it steers it back to the requester that issued it.

## Interface
- `N`, 32, operand/sum width
- `NREQ`, 4, number of requesters (2..16)
- `LATENCY`, 4, adder cycles from `valid_in` to `valid_out`; must equal the instantiated adder's depth
- `clk`  in  1  clock; all logic on rising edge
- `rstn`  in  1  reset; asynchronous, active-low
- `req_valid`  in  NREQ  request pending, one bit per requester
- `req_ready`  out  NREQ  grant; combinational, one-hot or zero
- `req_a`, `req_b`  in  NREQ×N  operands per requester
- `req_cin`  in  NREQ  carry-in per requester
- `add_a`, `add_b`  out  N  to adder `a`, `b` (registered)
- `add_cin`, `add_valid_in`  out  1  to adder `cin`, `valid_in` (registered)
- `add_s`  in  N  from adder `s`
- `add_cout`, `add_valid_out`  in  1  from adder `cout`, `valid_out`
- `rsp_valid`  out  NREQ  one-hot result strobe (registered)
- `rsp_sum`  out  N  result sum (registered)
- `rsp_cout`  out  1  result carry (registered)
- `busy`  out  1  any operation accepted but not yet returned
- `err`  out  1  sticky; adder output valid disagrees with tag pipeline

## Operation
- Arbitration: search `req_valid` starting at pointer `ptr`; first set bit `i` gets `req_ready[i]=1`. Transfer occurs when `req_valid[i] & req_ready[i]`.
- On transfer to `i`: `ptr <= (i+1) mod NREQ`. With no transfer, `ptr` holds. This gives at most one grant per cycle.
- `req_ready` is never asserted for a requester whose `req_valid` is low. A requester may hold valid without being granted for up to `NREQ-1` cycles.
- Issue stage: on transfer, register the operands of `i` into `add_a/add_b/add_cin` and set `add_valid_in=1`. With no transfer, drive `add_valid_in=0` and hold the operand registers.
- Tag pipeline: a `LATENCY`-deep shift register of {valid, id}. It advances every cycle and is loaded with {`add_valid_in`, issued id}, so the tail aligns with `add_valid_out`.
- Return: when `add_valid_out` and the tail is valid, the next cycle sets `rsp_valid[tail.id]=1`, `rsp_sum=add_s`, `rsp_cout=add_cout`. Otherwise `rsp_valid=0` and `rsp_sum/rsp_cout` hold.
- Sums are N-bit modulo 2^N; the carry appears only on `rsp_cout`. No width extension.
- `err` sets when `add_valid_out != tail.valid`, and clears only on reset. On a mismatch no `rsp_valid` is raised.
- `busy` = `add_valid_in` | OR of tag valids | any `rsp_valid`.

## Timing
- Reset (`rstn` low, asynchronous): `req_ready`=0 while no valid is present. All registered outputs are 0: `add_*`, `rsp_*`, `busy`, `err`. `ptr`=0 and the tag pipeline is cleared.
- Reset mid-flight discards in-flight operations. No `rsp_valid` appears for them after release.
- Latency: transfer in cycle T gives `add_valid_in` in T+1, `add_valid_out` in T+1+LATENCY, and `rsp_valid` in T+2+LATENCY (6 cycles at default).
- Throughput: one operation per cycle sustained. Results return in acceptance order.
- Simultaneous issue and return in the same cycle are independent; no conflict.

## Configuration
- `ADDER_ARB_FIXED_PRIO_EN` defined: fixed priority, where the lowest index always wins. `ptr` is removed and starvation is possible.
- Not defined: round-robin as described in Operation.

## Structure
- Package `adder_arb_pkg`:
  - `req_id_t` (`$clog2(NREQ)` bits)
  - `tag_t` struct {`valid`, `id`}
  - default `N`/`NREQ`/`LATENCY` constants
- Sub-module `rr_arbiter`: takes `req_valid`, produces one-hot grant plus encoded id, and holds `ptr`. The fixed-priority macro is handled inside it.
- The top level holds the issue registers, tag pipeline, return registers and `err`.

## Test plan
- Reset, then requester 0: a=283, b=50, cin=0 for one cycle -> `rsp_valid`=4'b0001, `rsp_sum`=333, `rsp_cout`=0, exactly 6 cycles after acceptance.
- All four `req_valid` held high for 8 cycles -> grant order 0,1,2,3,0,1,2,3. `rsp_valid` follows the same order, one per cycle, 6 cycles later.
- Requester 2: a=32'hFFFF_FFFF, b=1, cin=0 -> `rsp_valid[2]`, `rsp_sum`=0, `rsp_cout`=1. Requester 1: a=0, b=0, cin=1 -> `rsp_sum`=1.
- Issue 3 ops, then assert `rstn`=0 for 2 cycles during flight -> no `rsp_valid` afterwards, `busy`=0, `ptr` restarts at 0.
- Bench forces `add_valid_out`=1 with an empty tag pipeline -> `err`=1 next cycle and stays 1; no `rsp_valid`.
- With `ADDER_ARB_FIXED_PRIO_EN`, requesters 1 and 3 held valid -> requester 1 granted every cycle, 3 never granted.

Source files
------------

// File: rtl/adder_arb_pkg.sv
// Shared types and default sizing for the adder arbiter slice.
package adder_arb_pkg;

    localparam int N_DEF       = 32;
    localparam int NREQ_DEF    = 4;
    localparam int LATENCY_DEF = 4;

    localparam int ID_W = (NREQ_DEF > 1) ? $clog2(NREQ_DEF) : 1;

    typedef logic [ID_W-1:0] req_id_t;

    // One slot of the tag pipeline that travels alongside the adder.
    typedef struct packed {
        logic    valid;
        req_id_t id;
    } tag_t;

    // Requester index after id, wrapping at nreq (nreq need not be a power of two).
    function automatic req_id_t next_id(input req_id_t id, input int nreq);
        if (int'(id) == nreq - 1) begin
            return '0;
        end
        return id + req_id_t'(1);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Single-grant arbiter for the shared adder.
// ADDER_ARB_FIXED_PRIO_EN: when defined, lowest index always wins and the
// rotating pointer (and its clock/reset ports) disappear.
module rr_arbiter
    import adder_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEF
)
(
`ifndef ADDER_ARB_FIXED_PRIO_EN
    input  logic            clk,
    input  logic            rstn,
`endif
    input  logic [NREQ-1:0] req_valid,
    output logic [NREQ-1:0] grant,
    output req_id_t         grant_id,
    output logic            grant_any
);

`ifdef ADDER_ARB_FIXED_PRIO_EN

    // Lowest-index requester wins; scanning downwards leaves the lowest hit last.
    always_comb begin
        // NOTE: every output gets a default before any branch so no latch is inferred.
        grant     = '0;
        grant_id  = '0;
        grant_any = 1'b0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                grant_id  = req_id_t'(i);
                grant_any = 1'b1;
            end
        end
        if (grant_any) begin
            grant[grant_id] = 1'b1;
        end
    end

`else

    req_id_t ptr;

    // Search req_valid starting at ptr; the first set bit is granted.
    always_comb begin
        int idx;
        // NOTE: every output gets a default before any branch so no latch is inferred.
        idx       = 0;
        grant     = '0;
        grant_id  = '0;
        grant_any = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!grant_any && req_valid[idx]) begin
                grant_any = 1'b1;
                grant_id  = req_id_t'(idx);
            end
        end
        if (grant_any) begin
            grant[grant_id] = 1'b1;
        end
    end

    // Pointer moves just past the winner on a transfer and holds otherwise.
    always_ff @(posedge clk or negedge rstn) begin
        // NOTE: state registers use non-blocking assignment so all flops update together.
        if (!rstn) begin
            ptr <= '0;
        end else if (grant_any) begin
            ptr <= next_id(grant_id, NREQ);
        end
    end

`endif

endmodule

// File: rtl/adder_arbiter.sv
// Shares one fixed-latency pipelined adder among NREQ requesters: one
// valid/ready transfer per cycle, operands registered into the adder, the
// requester id carried in a tag pipeline, and the sum steered back on return.
// ADDER_ARB_FIXED_PRIO_EN: selects fixed priority (lowest index) in the arbiter.
module adder_arbiter
    import adder_arb_pkg::*;
#(
    parameter int N       = N_DEF,
    parameter int NREQ    = NREQ_DEF,
    parameter int LATENCY = LATENCY_DEF
)
(
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ-1:0][N-1:0]   req_a,
    input  logic [NREQ-1:0][N-1:0]   req_b,
    input  logic [NREQ-1:0]          req_cin,
    output logic [N-1:0]             add_a,
    output logic [N-1:0]             add_b,
    output logic                     add_cin,
    output logic                     add_valid_in,
    input  logic [N-1:0]             add_s,
    input  logic                     add_cout,
    input  logic                     add_valid_out,
    output logic [NREQ-1:0]          rsp_valid,
    output logic [N-1:0]             rsp_sum,
    output logic                     rsp_cout,
    output logic                     busy,
    output logic                     err
);

    logic [NREQ-1:0] grant;
    req_id_t         grant_id;
    logic            xfer;
    req_id_t         issue_id;
    tag_t            tag_q [LATENCY];
    tag_t            tail;
    logic            tag_any;
    logic            ret_ok;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
`ifndef ADDER_ARB_FIXED_PRIO_EN
        .clk       (clk),
        .rstn      (rstn),
`endif
        .req_valid (req_valid),
        .grant     (grant),
        .grant_id  (grant_id),
        .grant_any (xfer)
    );

    // Grant is only ever raised on a valid requester, so a grant is a transfer.
    assign req_ready = grant;

    // Issue stage: capture the winner's operands; hold them when idle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            add_a        <= '0;
            add_b        <= '0;
            add_cin      <= 1'b0;
            add_valid_in <= 1'b0;
            issue_id     <= '0;
        end else begin
            add_valid_in <= xfer;
            if (xfer) begin
                add_a    <= req_a[grant_id];
                add_b    <= req_b[grant_id];
                add_cin  <= req_cin[grant_id];
                issue_id <= grant_id;
            end
        end
    end

    // Tag pipeline: same depth as the adder so the tail lines up with add_valid_out.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            // NOTE: this array is reset because its valid bits are control state;
            // leaving it unreset would let stale tags return after a mid-flight reset.
            for (int i = 0; i < LATENCY; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            tag_q[0] <= tag_t'{valid: add_valid_in, id: issue_id};
            for (int i = 1; i < LATENCY; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    assign tail   = tag_q[LATENCY-1];
    assign ret_ok = add_valid_out & tail.valid;

    // Return stage: strobe the owner of the emerging result; hold data when idle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rsp_valid <= '0;
            rsp_sum   <= '0;
            rsp_cout  <= 1'b0;
        end else begin
            rsp_valid <= '0;
            if (ret_ok) begin
                rsp_valid[tail.id] <= 1'b1;
                rsp_sum            <= add_s;
                rsp_cout           <= add_cout;
            end
        end
    end

    // Sticky error when the adder's valid and our tag pipeline disagree.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            err <= 1'b0;
        end else if (add_valid_out != tail.valid) begin
            err <= 1'b1;
        end
    end

    // Any operation still in the issue register, the tag pipeline or the return strobe.
    always_comb begin
        tag_any = 1'b0;
        for (int i = 0; i < LATENCY; i++) begin
            tag_any = tag_any | tag_q[i].valid;
        end
    end

    assign busy = add_valid_in | tag_any | (|rsp_valid);

endmodule

// File: tb/tb_adder_arbiter.sv
// Self-checking bench for adder_arbiter with a behavioural adder and a
// scoreboard of expected responses keyed by due cycle.
module tb_adder_arbiter;

    localparam int N         = 32;
    localparam int NREQ      = 4;
    localparam int LATENCY   = 4;
    localparam int RSP_DELAY = LATENCY + 2;

    logic                   clk = 1'b0;
    logic                   rstn = 1'b0;
    logic [NREQ-1:0]        req_valid = '0;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ-1:0][N-1:0] req_a = '0;
    logic [NREQ-1:0][N-1:0] req_b = '0;
    logic [NREQ-1:0]        req_cin = '0;
    logic [N-1:0]           add_a, add_b, add_s;
    logic                   add_cin, add_valid_in, add_cout, add_valid_out;
    logic [NREQ-1:0]        rsp_valid;
    logic [N-1:0]           rsp_sum;
    logic                   rsp_cout, busy, err;
    logic                   force_vo = 1'b0;

    always #5 clk = ~clk;

    adder_arbiter #(.N(N), .NREQ(NREQ), .LATENCY(LATENCY)) dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_valid_in(add_valid_in),
        .add_s(add_s), .add_cout(add_cout), .add_valid_out(add_valid_out),
        .rsp_valid(rsp_valid), .rsp_sum(rsp_sum), .rsp_cout(rsp_cout),
        .busy(busy), .err(err)
    );

    // Behavioural pipelined adder, LATENCY stages, cleared by reset.
    logic         pv [LATENCY];
    logic [N:0]   pr [LATENCY];

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < LATENCY; i++) begin
                pv[i] <= 1'b0;
                pr[i] <= '0;
            end
        end else begin
            pv[0] <= add_valid_in;
            pr[0] <= {1'b0, add_a} + {1'b0, add_b} + {{N{1'b0}}, add_cin};
            for (int i = 1; i < LATENCY; i++) begin
                pv[i] <= pv[i-1];
                pr[i] <= pr[i-1];
            end
        end
    end

    assign add_s         = pr[LATENCY-1][N-1:0];
    assign add_cout      = pr[LATENCY-1][N];
    assign add_valid_out = pv[LATENCY-1] | force_vo;

    // Reference model state
    typedef struct {
        int           id;
        logic [N-1:0] sum;
        logic         cout;
        int           due;
    } exp_t;

    exp_t            sb[$];
    int              checks = 0;
    int              errors = 0;
    int              cyc = 0;
    int              m_ptr = 0;
    logic [N-1:0]    ra [NREQ];
    logic [N-1:0]    rb [NREQ];
    logic            rc [NREQ];
    logic [NREQ-1:0] obs_ready;

    function automatic int exp_grant(input logic [NREQ-1:0] v);
`ifdef ADDER_ARB_FIXED_PRIO_EN
        for (int i = 0; i < NREQ; i++) begin
            if (v[i]) return i;
        end
`else
        for (int k = 0; k < NREQ; k++) begin
            if (v[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
        end
`endif
        return -1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // One clock of traffic: checks grant, then busy and the response port.
    task automatic do_cycle(input logic [NREQ-1:0] v);
        int              g;
        logic [NREQ-1:0] exp_rdy;
        logic [NREQ-1:0] exp_rv;
        logic [N:0]      full;
        logic            exp_busy;
        exp_t            e;
        for (int i = 0; i < NREQ; i++) begin
            req_a[i]   = ra[i];
            req_b[i]   = rb[i];
            req_cin[i] = rc[i];
        end
        req_valid = v;
        #1;
        g = exp_grant(v);
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        obs_ready = req_ready;
        checks++;
        if (req_ready !== exp_rdy) begin
            errors++;
            $display("FAIL grant cyc=%0d valid=%b got %b expected %b", cyc, v, req_ready, exp_rdy);
        end
        if (g >= 0) begin
            full   = {1'b0, ra[g]} + {1'b0, rb[g]} + {{N{1'b0}}, rc[g]};
            e.id   = g;
            e.sum  = full[N-1:0];
            e.cout = full[N];
            e.due  = cyc + RSP_DELAY;
            sb.push_back(e);
`ifndef ADDER_ARB_FIXED_PRIO_EN
            m_ptr = (g + 1) % NREQ;
`endif
        end
        step();
        exp_busy = (sb.size() != 0);
        checks++;
        if (busy !== exp_busy) begin
            errors++;
            $display("FAIL busy cyc=%0d got %b expected %b", cyc, busy, exp_busy);
        end
        exp_rv = '0;
        if (sb.size() != 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            exp_rv[e.id] = 1'b1;
            checks++;
            if (rsp_valid !== exp_rv || rsp_sum !== e.sum || rsp_cout !== e.cout) begin
                errors++;
                $display("FAIL response cyc=%0d got v=%b s=%h c=%b expected v=%b s=%h c=%b",
                         cyc, rsp_valid, rsp_sum, rsp_cout, exp_rv, e.sum, e.cout);
            end
        end else begin
            checks++;
            if (rsp_valid !== exp_rv) begin
                errors++;
                $display("FAIL rsp_idle cyc=%0d got %b expected %b", cyc, rsp_valid, exp_rv);
            end
        end
    endtask

    task automatic do_reset(input int n);
        rstn      = 1'b0;
        req_valid = '0;
        force_vo  = 1'b0;
        repeat (n) step();
        sb.delete();
        m_ptr = 0;
        rstn  = 1'b1;
    endtask

    task automatic test_reset();
        rstn      = 1'b0;
        req_valid = '0;
        repeat (2) step();
        checks++;
        if ({req_ready, add_valid_in, add_cin, rsp_valid, rsp_cout, busy, err} !== '0) begin
            errors++;
            $display("FAIL reset_ctrl got rdy=%b avi=%b cin=%b rv=%b rc=%b busy=%b err=%b expected all 0",
                     req_ready, add_valid_in, add_cin, rsp_valid, rsp_cout, busy, err);
        end
        checks++;
        if ({add_a, add_b, rsp_sum} !== '0) begin
            errors++;
            $display("FAIL reset_data got a=%h b=%h sum=%h expected 0", add_a, add_b, rsp_sum);
        end
        rstn = 1'b1;
        for (int i = 0; i < 3; i++) do_cycle('0);
    endtask

    task automatic test_single();
        int acc;
        int seen;
        logic [N-1:0] s;
        for (int i = 0; i < NREQ; i++) begin ra[i] = '0; rb[i] = '0; rc[i] = 1'b0; end
        ra[0] = 32'd283;
        rb[0] = 32'd50;
        acc   = cyc;
        seen  = -1;
        s     = '0;
        do_cycle(4'b0001);
        for (int i = 0; i < 10; i++) begin
            do_cycle('0);
            if (rsp_valid !== '0 && seen < 0) begin
                seen = cyc;
                s    = rsp_sum;
                checks++;
                if (rsp_valid !== 4'b0001 || rsp_sum !== 32'd333 || rsp_cout !== 1'b0) begin
                    errors++;
                    $display("FAIL single_result got v=%b s=%0d c=%b expected v=0001 s=333 c=0",
                             rsp_valid, rsp_sum, rsp_cout);
                end
            end
        end
        checks++;
        if (seen - acc != 6) begin
            errors++;
            $display("FAIL single_latency got %0d expected 6 (sum %0d)", seen - acc, s);
        end
    endtask

    task automatic test_round_robin();
        logic [NREQ-1:0] order[$];
        do_reset(1);
        for (int i = 0; i < NREQ; i++) begin
            ra[i] = $urandom; rb[i] = $urandom; rc[i] = 1'($urandom);
        end
        for (int i = 0; i < 8; i++) begin
            do_cycle(4'b1111);
            checks++;
            if (obs_ready !== 4'(1 << (i % NREQ))) begin
                errors++;
                $display("FAIL rr_order slot=%0d got %b expected %b", i, obs_ready, 4'(1 << (i % NREQ)));
            end
            if (rsp_valid !== '0) order.push_back(rsp_valid);
        end
        for (int i = 0; i < 8; i++) begin
            do_cycle('0);
            if (rsp_valid !== '0) order.push_back(rsp_valid);
        end
        checks++;
        if (order.size() != 8) begin
            errors++;
            $display("FAIL rr_rsp_count got %0d expected 8", order.size());
        end
        for (int i = 0; i < order.size(); i++) begin
            checks++;
            if (order[i] !== 4'(1 << (i % NREQ))) begin
                errors++;
                $display("FAIL rr_rsp_order slot=%0d got %b expected %b", i, order[i], 4'(1 << (i % NREQ)));
            end
        end
    endtask

    task automatic test_boundary();
        int got2, got1;
        got2 = 0;
        got1 = 0;
        ra[2] = 32'hFFFF_FFFF; rb[2] = 32'd1; rc[2] = 1'b0;
        ra[1] = 32'd0;         rb[1] = 32'd0; rc[1] = 1'b1;
        do_cycle(4'b0100);
        do_cycle(4'b0010);
        for (int i = 0; i < 9; i++) begin
            do_cycle('0);
            if (rsp_valid === 4'b0100) begin
                got2++;
                checks++;
                if (rsp_sum !== 32'd0 || rsp_cout !== 1'b1) begin
                    errors++;
                    $display("FAIL wrap_sum got s=%h c=%b expected s=0 c=1", rsp_sum, rsp_cout);
                end
            end
            if (rsp_valid === 4'b0010) begin
                got1++;
                checks++;
                if (rsp_sum !== 32'd1 || rsp_cout !== 1'b0) begin
                    errors++;
                    $display("FAIL cin_sum got s=%h c=%b expected s=1 c=0", rsp_sum, rsp_cout);
                end
            end
        end
        checks++;
        if (got2 != 1 || got1 != 1) begin
            errors++;
            $display("FAIL boundary_count got r2=%0d r1=%0d expected 1 and 1", got2, got1);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                case ($urandom_range(0, 7))
                    0:       begin ra[i] = '1; rb[i] = $urandom; end
                    1:       begin ra[i] = '0; rb[i] = '0; end
                    default: begin ra[i] = $urandom; rb[i] = $urandom; end
                endcase
                rc[i] = 1'($urandom);
            end
            do_cycle(4'($urandom_range(0, 15)));
        end
        for (int i = 0; i < 8; i++) do_cycle('0);
        checks++;
        if (err !== 1'b0 || sb.size() != 0) begin
            errors++;
            $display("FAIL random_drain got err=%b pending=%0d expected 0 and 0", err, sb.size());
        end
    endtask

    task automatic test_reset_flight();
        for (int i = 0; i < NREQ; i++) begin
            ra[i] = $urandom; rb[i] = $urandom; rc[i] = 1'($urandom);
        end
        for (int i = 0; i < 3; i++) do_cycle(4'b0111);
        req_valid = '0;
        rstn = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || rsp_valid !== '0 || add_valid_in !== 1'b0) begin
            errors++;
            $display("FAIL flight_reset got busy=%b rv=%b avi=%b expected 0", busy, rsp_valid, add_valid_in);
        end
        step();
        step();
        sb.delete();
        m_ptr = 0;
        rstn  = 1'b1;
        for (int i = 0; i < 10; i++) do_cycle('0);
        do_cycle(4'b1111);
        checks++;
        if (obs_ready !== 4'b0001) begin
            errors++;
            $display("FAIL ptr_restart got %b expected 0001", obs_ready);
        end
        for (int i = 0; i < 7; i++) do_cycle('0);
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL flight_err got %b expected 0", err);
        end
    endtask

    task automatic test_err();
        force_vo = 1'b1;
        do_cycle('0);
        force_vo = 1'b0;
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL err_set got %b expected 1", err);
        end
        for (int i = 0; i < 3; i++) begin
            do_cycle('0);
            checks++;
            if (err !== 1'b1) begin
                errors++;
                $display("FAIL err_sticky cyc=%0d got %b expected 1", cyc, err);
            end
        end
        do_reset(1);
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL err_clear got %b expected 0", err);
        end
    endtask

`ifdef ADDER_ARB_FIXED_PRIO_EN
    task automatic test_fixed_prio();
        int hits3;
        hits3 = 0;
        for (int i = 0; i < NREQ; i++) begin
            ra[i] = $urandom; rb[i] = $urandom; rc[i] = 1'b0;
        end
        for (int i = 0; i < 6; i++) begin
            do_cycle(4'b1010);
            if (obs_ready[3]) hits3++;
            checks++;
            if (obs_ready !== 4'b0010) begin
                errors++;
                $display("FAIL fixed_prio slot=%0d got %b expected 0010", i, obs_ready);
            end
        end
        checks++;
        if (hits3 != 0) begin
            errors++;
            $display("FAIL fixed_starve got %0d grants to 3 expected 0", hits3);
        end
        for (int i = 0; i < 8; i++) do_cycle('0);
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired before summary");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < NREQ; i++) begin ra[i] = '0; rb[i] = '0; rc[i] = 1'b0; end
        test_reset();
        test_single();
`ifndef ADDER_ARB_FIXED_PRIO_EN
        test_round_robin();
`else
        test_fixed_prio();
`endif
        test_boundary();
        test_random();
        test_reset_flight();
        test_err();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
